// File: rtl/ysyx_23060184_csr_unit.sv
// CSR execution unit: takes one Zicsr/system instruction, reads the CSR,
// commits the read-modify-write result to the register file, and returns
// the old value (or trap/return target) to writeback with a PC redirect.
module ysyx_23060184_csr_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_pc,
  input  logic [2:0]                in_op,
  input  logic                      in_ecall,
  input  logic                      in_mret,
  input  logic [CSR_ADDR_WIDTH-1:0] in_csr,
  input  logic [4:0]                in_rs1_idx,
  input  logic [DATA_WIDTH-1:0]     in_rs1_data,
  input  logic [4:0]                in_zimm,
  input  logic [4:0]                in_rd,
  output logic [CSR_ADDR_WIDTH-1:0] csr_raddr,
  input  logic [DATA_WIDTH-1:0]     csr_rdata,
  output logic [CSR_ADDR_WIDTH-1:0] csr_waddr,
  output logic [DATA_WIDTH-1:0]     csr_wdata,
  output logic                      csr_wen,
  output logic                      csr_ecall,
  output logic                      csr_mret,
  output logic [DATA_WIDTH-1:0]     csr_pc,
  output logic                      csr_wvalid,
  input  logic                      csr_pready,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [4:0]                wb_rd,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      redirect_valid,
  output logic [DATA_WIDTH-1:0]     redirect_pc
);

  typedef enum logic [1:0] {IDLE, READ, COMMIT, RESP} state_t;
  typedef enum logic [1:0] {CLS_NONE, CLS_CSR, CLS_ECALL, CLS_MRET} cls_t;

  // mcause code for an environment call from M-mode
  localparam logic [DATA_WIDTH-1:0] MCAUSE_ECALL_M = DATA_WIDTH'(11);

  state_t state;
  cls_t   cls_q;
  cls_t   cls_in;

  logic                      accept;
  logic [DATA_WIDTH-1:0]     pc_q;
  logic [2:0]                op_q;
  logic [CSR_ADDR_WIDTH-1:0] csr_q;
  logic [4:0]                rs1_idx_q;
  logic [DATA_WIDTH-1:0]     rs1_data_q;
  logic [4:0]                zimm_q;
  logic [4:0]                rd_q;
  logic [DATA_WIDTH-1:0]     old_q;
  logic [DATA_WIDTH-1:0]     src;

  // Read-modify-write result selected by funct3[1:0]
  function automatic logic [DATA_WIDTH-1:0] csr_new(input logic [2:0] op,
                                                    input logic [DATA_WIDTH-1:0] old,
                                                    input logic [DATA_WIDTH-1:0] s);
    case (op[1:0])
      2'b01:   csr_new = s;
      2'b10:   csr_new = old | s;
      2'b11:   csr_new = old & ~s;
      default: csr_new = old;
    endcase
  endfunction

  // Set/clear with an x0/zero source must not write (no side effects)
  function automatic logic csr_wneed(input cls_t cls, input logic [2:0] op,
                                     input logic [4:0] rs1_idx, input logic [4:0] zimm);
    if (cls != CLS_CSR)       csr_wneed = 1'b0;
    else if (op[1:0] == 2'b01) csr_wneed = 1'b1;
    else if (op[2])           csr_wneed = (zimm != 5'd0);
    else                      csr_wneed = (rs1_idx != 5'd0);
  endfunction

  assign accept = in_valid & in_ready;

  // Instruction class at capture: ECALL beats MRET, both override funct3
  always_comb begin
    cls_in = CLS_NONE;
    if (in_ecall)                cls_in = CLS_ECALL;
    else if (in_mret)            cls_in = CLS_MRET;
    else if (in_op[1:0] != 2'b00) cls_in = CLS_CSR;
  end

  // Source operand: zero-extended zimm for immediate forms, else rs1
  always_comb begin
    src = op_q[2] ? DATA_WIDTH'(zimm_q) : rs1_data_q;
  end

  // Instruction fields and old CSR value; data only, no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_q       <= in_pc;
      op_q       <= in_op;
      csr_q      <= in_csr;
      rs1_idx_q  <= in_rs1_idx;
      rs1_data_q <= in_rs1_data;
      zimm_q     <= in_zimm;
      rd_q       <= in_rd;
    end
    if (state == READ) old_q <= csr_rdata;
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cls_q          <= CLS_NONE;
      in_ready       <= 1'b1;
      csr_raddr      <= '0;
      csr_waddr      <= '0;
      csr_wdata      <= '0;
      csr_wen        <= 1'b0;
      csr_ecall      <= 1'b0;
      csr_mret       <= 1'b0;
      csr_pc         <= '0;
      csr_wvalid     <= 1'b0;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= READ;
            in_ready  <= 1'b0;
            cls_q     <= cls_in;
            csr_raddr <= in_csr;
            csr_ecall <= (cls_in == CLS_ECALL);
            csr_mret  <= (cls_in == CLS_MRET);
          end
        end
        // READ -> COMMIT: old value arrives on csr_rdata this cycle
        READ: begin
          state      <= COMMIT;
          csr_wvalid <= 1'b1;
          csr_waddr  <= csr_q;
          csr_wen    <= csr_wneed(cls_q, op_q, rs1_idx_q, zimm_q);
          csr_wdata  <= (cls_q == CLS_ECALL) ? MCAUSE_ECALL_M
                                             : csr_new(op_q, csr_rdata, src);
          csr_pc     <= (cls_q == CLS_ECALL) ? pc_q : '0;
        end
        // COMMIT -> RESP: everything held until the register file accepts
        COMMIT: begin
          if (csr_pready) begin
            state          <= RESP;
            csr_wvalid     <= 1'b0;
            csr_wen        <= 1'b0;
            csr_waddr      <= '0;
            csr_wdata      <= '0;
            csr_pc         <= '0;
            csr_ecall      <= 1'b0;
            csr_mret       <= 1'b0;
            wb_valid       <= 1'b1;
            wb_data        <= old_q;
            wb_rd          <= (cls_q == CLS_CSR) ? rd_q : 5'd0;
            redirect_valid <= (cls_q == CLS_ECALL) || (cls_q == CLS_MRET);
            redirect_pc    <= ((cls_q == CLS_ECALL) || (cls_q == CLS_MRET)) ? old_q : '0;
          end
        end
        // RESP -> IDLE: hold result until writeback takes it
        RESP: begin
          if (wb_ready) begin
            state          <= IDLE;
            in_ready       <= 1'b1;
            csr_raddr      <= '0;
            wb_valid       <= 1'b0;
            wb_rd          <= '0;
            wb_data        <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060184_csr_unit.sv
// Directed bench for ysyx_23060184_csr_unit: a small CSR read model drives
// csr_rdata, and each step checks outputs at the falling edge.
module tb_ysyx_23060184_csr_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_pc;
  logic [2:0]  in_op;
  logic        in_ecall, in_mret;
  logic [9:0]  in_csr;
  logic [4:0]  in_rs1_idx;
  logic [31:0] in_rs1_data;
  logic [4:0]  in_zimm, in_rd;
  logic [9:0]  csr_raddr, csr_waddr;
  logic [31:0] csr_rdata, csr_wdata, csr_pc;
  logic        csr_wen, csr_ecall, csr_mret, csr_wvalid, csr_pready;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic [31:0] rd_v, mtvec_v, mepc_v;
  int total = 0, bad = 0;
  int hs_cnt = 0, wr_cnt = 0, wb_cnt = 0;
  int hs0, wr0, wb0, lowcyc;

  always #5 clk = ~clk;

  // Register-file read mux model: ECALL reads mtvec, MRET reads mepc
  assign csr_rdata = csr_ecall ? mtvec_v : (csr_mret ? mepc_v : rd_v);

  ysyx_23060184_csr_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_op(in_op), .in_ecall(in_ecall), .in_mret(in_mret),
    .in_csr(in_csr), .in_rs1_idx(in_rs1_idx), .in_rs1_data(in_rs1_data),
    .in_zimm(in_zimm), .in_rd(in_rd), .csr_raddr(csr_raddr),
    .csr_rdata(csr_rdata), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_wen(csr_wen), .csr_ecall(csr_ecall), .csr_mret(csr_mret),
    .csr_pc(csr_pc), .csr_wvalid(csr_wvalid), .csr_pready(csr_pready),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  // Handshake counters
  always @(posedge clk) begin
    if (csr_wvalid && csr_pready)            hs_cnt <= hs_cnt + 1;
    if (csr_wvalid && csr_pready && csr_wen) wr_cnt <= wr_cnt + 1;
    if (wb_valid && wb_ready)                wb_cnt <= wb_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one instruction for a single cycle, then scramble the inputs
  task automatic issue(input logic [2:0] op, input logic ec, input logic mr,
                       input logic [9:0] csr, input logic [4:0] idx,
                       input logic [31:0] data, input logic [4:0] zimm,
                       input logic [4:0] rd, input logic [31:0] pc);
    in_valid = 1'b1; in_op = op; in_ecall = ec; in_mret = mr; in_csr = csr;
    in_rs1_idx = idx; in_rs1_data = data; in_zimm = zimm; in_rd = rd; in_pc = pc;
    step();
    in_valid = 1'b0; in_op = 3'b001; in_ecall = 1'b1; in_mret = 1'b1;
    in_csr = 10'h3FF; in_rs1_idx = 5'h1F; in_rs1_data = 32'hFFFF_FFFF;
    in_zimm = 5'h1F; in_rd = 5'h1F; in_pc = 32'hFFFF_FFFF;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 3'b000; in_ecall = 1'b0; in_mret = 1'b0;
    in_csr = '0; in_rs1_idx = '0; in_rs1_data = '0; in_zimm = '0; in_rd = '0;
    in_pc = '0; csr_pready = 1'b1; wb_ready = 1'b1;
    rd_v = '0; mtvec_v = '0; mepc_v = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ctrl", {csr_wvalid, csr_wen, csr_ecall, csr_mret, wb_valid, redirect_valid}, 0);
    chk("rst_data", csr_wdata | csr_pc | wb_data | redirect_pc | csr_raddr | csr_waddr | wb_rd, 0);
    rst = 1'b0;
    step();

    // CSRRW x5, mstatus, rs1=0xDEADBEEF, old 0x1800
    rd_v = 32'h1800;
    issue(3'b001, 0, 0, 10'h300, 5'd7, 32'hDEAD_BEEF, 5'd0, 5'd5, 32'h8000_0000);
    chk("rw_read_ready", in_ready, 0);
    chk("rw_raddr", csr_raddr, 10'h300);
    chk("rw_read_ecmr", {csr_ecall, csr_mret, csr_wvalid}, 0);
    step();
    rd_v = 32'h0BAD_0BAD;
    chk("rw_commit", {csr_wvalid, csr_wen}, 2'b11);
    chk("rw_waddr", csr_waddr, 10'h300);
    chk("rw_wdata", csr_wdata, 32'hDEAD_BEEF);
    step();
    chk("rw_wb", {wb_valid, redirect_valid, csr_wvalid}, 3'b100);
    chk("rw_wb_rd", wb_rd, 5);
    chk("rw_wb_data", wb_data, 32'h1800);
    step();
    chk("rw_idle", {in_ready, wb_valid}, 2'b10);
    chk("rw_writes", wr_cnt, 1);

    // CSRRS with rs1=x0 on mcause=0xB: no write
    rd_v = 32'hB;
    issue(3'b010, 0, 0, 10'h342, 5'd0, 32'h0000_FFFF, 5'd0, 5'd6, 32'h0);
    step();
    chk("rs0_commit", {csr_wvalid, csr_wen}, 2'b10);
    step();
    chk("rs0_wb_data", wb_data, 32'hB);
    chk("rs0_wb_rd", wb_rd, 6);
    step();

    // CSRRCI zimm=3 on mstatus=0xF -> 0xC
    rd_v = 32'hF;
    issue(3'b111, 0, 0, 10'h300, 5'd9, 32'hFFFF_FFFF, 5'd3, 5'd8, 32'h0);
    step();
    chk("rci_wen", csr_wen, 1);
    chk("rci_wdata", csr_wdata, 32'hC);
    step();
    chk("rci_wb_data", wb_data, 32'hF);
    step();

    // CSRRC rs1 nonzero: 0xFFF & ~0xF0 = 0xF0F
    rd_v = 32'hFFF;
    issue(3'b011, 0, 0, 10'h304, 5'd1, 32'h0F0, 5'd0, 5'd2, 32'h0);
    step();
    chk("rc_wdata", {31'd0, csr_wen} << 16 | csr_wdata, 32'h0001_0F0F);
    step(); step();

    // CSRRWI with zimm=0 still writes zero
    rd_v = 32'h1234;
    issue(3'b101, 0, 0, 10'h305, 5'd4, 32'hFFFF_FFFF, 5'd0, 5'd9, 32'h0);
    step();
    chk("rwi0_wen", csr_wen, 1);
    chk("rwi0_wdata", csr_wdata, 32'h0);
    step();
    chk("rwi0_wb", {27'd0, wb_rd} ^ wb_data, 32'h1234 ^ 32'd9);
    step();

    // ECALL (with MRET also set) at 0x80000010, mtvec=0x80000100
    rd_v = 32'h1234_5678; mtvec_v = 32'h8000_0100; mepc_v = 32'h8000_0999;
    issue(3'b001, 1, 1, 10'h300, 5'd1, 32'h1, 5'd0, 5'd7, 32'h8000_0010);
    chk("ec_read_ecmr", {csr_ecall, csr_mret}, 2'b10);
    step();
    chk("ec_commit_ctl", {csr_wvalid, csr_wen, csr_ecall, csr_mret}, 4'b1010);
    chk("ec_wdata", csr_wdata, 32'd11);
    chk("ec_pc", csr_pc, 32'h8000_0010);
    step();
    chk("ec_resp_ecmr", {csr_ecall, csr_mret}, 0);
    chk("ec_redirect_valid", redirect_valid, 1);
    chk("ec_redirect_pc", redirect_pc, 32'h8000_0100);
    chk("ec_wb_rd", wb_rd, 0);
    step();

    // MRET with mepc=0x80000014
    mepc_v = 32'h8000_0014;
    issue(3'b000, 0, 1, 10'h341, 5'd0, 32'h0, 5'd0, 5'd3, 32'h0);
    chk("mr_read_ecmr", {csr_ecall, csr_mret}, 2'b01);
    step();
    chk("mr_commit", {csr_wvalid, csr_wen, csr_mret}, 3'b101);
    step();
    chk("mr_redirect", {31'd0, redirect_valid}, 1);
    chk("mr_redirect_pc", redirect_pc, 32'h8000_0014);
    chk("mr_wb_rd", wb_rd, 0);
    step();

    // No-op funct3=100: full handshake, no write, rd forced to 0
    rd_v = 32'h55;
    issue(3'b100, 0, 0, 10'h340, 5'd3, 32'h7, 5'd3, 5'd4, 32'h0);
    step();
    chk("nop_commit", {csr_wvalid, csr_wen}, 2'b10);
    step();
    chk("nop_wb", {wb_valid, redirect_valid}, 2'b10);
    chk("nop_wb_rd", wb_rd, 0);
    chk("nop_wb_data", wb_data, 32'h55);
    step();

    // Back-pressure: pready low 3 cycles, wb_ready low 2 cycles
    csr_pready = 1'b0; wb_ready = 1'b0; rd_v = 32'hA;
    hs0 = hs_cnt; wr0 = wr_cnt; wb0 = wb_cnt;
    issue(3'b010, 0, 0, 10'h305, 5'd2, 32'h5, 5'd0, 5'd10, 32'h0);
    lowcyc = 1;
    step();
    rd_v = 32'hBAD;
    for (int i = 0; i < 3; i++) begin
      chk("bp_commit_hold", {in_ready, csr_wvalid, csr_wen, 6'd0, csr_waddr, csr_wdata[15:0]},
          {1'b0, 1'b1, 1'b1, 6'd0, 10'h305, 16'h000F});
      lowcyc++;
      step();
    end
    csr_pready = 1'b1;
    chk("bp_commit_last", {in_ready, csr_wvalid}, 2'b01);
    lowcyc++;
    step();
    csr_pready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("bp_resp_hold", {in_ready, wb_valid, 3'd0, wb_rd, wb_data[15:0]},
          {1'b0, 1'b1, 3'd0, 5'd10, 16'h000A});
      lowcyc++;
      step();
    end
    wb_ready = 1'b1;
    chk("bp_resp_last", {in_ready, wb_valid}, 2'b01);
    lowcyc++;
    step();
    chk("bp_idle", in_ready, 1);
    chk("bp_total_cycles", lowcyc + 1, 9);
    chk("bp_one_commit", {hs_cnt - hs0, wr_cnt - wr0, wb_cnt - wb0}, {32'd1, 32'd1, 32'd1});
    csr_pready = 1'b1;

    // Reset while stalled in COMMIT aborts the instruction
    csr_pready = 1'b0; rd_v = 32'h1;
    issue(3'b001, 0, 0, 10'h340, 5'd6, 32'h77, 5'd0, 5'd11, 32'h0);
    step();
    chk("ab_commit", csr_wvalid, 1);
    hs0 = hs_cnt; wr0 = wr_cnt; wb0 = wb_cnt;
    #2 rst = 1'b1;
    #1;
    chk("ab_async", {in_ready, csr_wvalid, csr_wen, wb_valid}, 4'b1000);
    @(negedge clk);
    rst = 1'b0; csr_pready = 1'b1;
    step();
    chk("ab_ready", {in_ready, wb_valid, csr_wvalid}, 3'b100);
    chk("ab_no_side_effect", {hs_cnt - hs0, wr_cnt - wr0, wb_cnt - wb0}, 0);

    // Next instruction completes normally: 0x1 | 0x10 = 0x11
    issue(3'b010, 0, 0, 10'h340, 5'd3, 32'h10, 5'd0, 5'd12, 32'h0);
    step();
    chk("post_wdata", csr_wdata, 32'h11);
    chk("post_wen", csr_wen, 1);
    step();
    chk("post_wb", {wb_valid, 2'd0, wb_rd, wb_data[23:0]}, {1'b1, 2'd0, 5'd12, 24'h000001});
    step();
    chk("post_idle", in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
